// File: rtl/mult_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mult_div_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        FIN
    } state_e;

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_magnitude.sv
// Combinational conditional two's complement; used both to take operand
// magnitudes and to restore the sign of a finished result.
module md_magnitude #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             negate_i,
    output logic [WIDTH-1:0] result_o
);

    assign result_o = negate_i ? -value_i : value_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one setup cycle, WIDTH shift-add or
// restoring-divide iterations, then a one-cycle FIN with the done pulse.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               div_zero_q, div_zero_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mult_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mult_next, div_next, prod_fixed;
    logic [WIDTH-1:0]   quo_fixed, rem_fixed;

    assign a_neg = op_is_signed(op_q) & a_q[WIDTH-1];
    assign b_neg = op_is_signed(op_q) & b_q[WIDTH-1];

    md_magnitude #(.WIDTH(WIDTH)) u_a_mag (.value_i(a_q), .negate_i(a_neg), .result_o(a_mag));
    md_magnitude #(.WIDTH(WIDTH)) u_b_mag (.value_i(b_q), .negate_i(b_neg), .result_o(b_mag));

    // p_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    assign mult_sum  = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_mag} : '0);
    assign mult_next = {mult_sum, p_q[WIDTH-1:1]};

    assign div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_mag};
    assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  p_q[WIDTH-2:0], 1'b1};

    md_magnitude #(.WIDTH(2*WIDTH)) u_prod_fix (
        .value_i(mult_next), .negate_i(a_neg ^ b_neg), .result_o(prod_fixed));
    md_magnitude #(.WIDTH(WIDTH)) u_quo_fix (
        .value_i(div_next[WIDTH-1:0]), .negate_i(a_neg ^ b_neg), .result_o(quo_fixed));
    md_magnitude #(.WIDTH(WIDTH)) u_rem_fix (
        .value_i(div_next[2*WIDTH-1:WIDTH]), .negate_i(a_neg), .result_o(rem_fixed));

    always_comb begin
        // NOTE: every next-state value gets a hold default first so no path infers a latch.
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        p_d        = p_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    state_d = op_is_div(op_e'(op)) ? DIV : MULT;
                end
            end
            MULT, DIV: begin
                if (cnt_q == '0) begin
                    if (state_q == DIV && b_q == '0) begin
                        div_zero_d = 1'b1;
                        state_d    = FIN;
                    end else begin
                        p_d   = {{WIDTH{1'b0}}, (state_q == MULT) ? b_mag : a_mag};
                        cnt_d = CNT_W'(1);
                    end
                end else begin
                    p_d   = (state_q == MULT) ? mult_next : div_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        state_d = FIN;
                        if (state_q == MULT) begin
                            {hi_d, lo_d} = prod_fixed;
                        end else begin
                            hi_d = rem_fixed;
                            lo_d = quo_fixed;
                        end
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state and datapath registers update with non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: datapath registers are plain flops, so clearing them all on reset is cheap.
            state_q    <= IDLE;
            op_q       <= OP_MULT;
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            p_q        <= p_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FIN);
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_mult_div_unit;
    import mult_div_pkg::*;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
        logic             dz;
    } res_t;

    logic             clock, reset, start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, div_zero;
    logic [WIDTH-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic res_t model_calc(input logic [1:0] o, input logic [WIDTH-1:0] av,
                                        input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] ohi,
                                        input logic [WIDTH-1:0] olo);
        res_t        r;
        longint      sa, sb;
        logic [63:0] p;
        r = '{hi: ohi, lo: olo, dz: 1'b0};
        sa = $signed(av);
        sb = $signed(bv);
        case (o)
            2'b00: begin p = sa * sb; {r.hi, r.lo} = p; end
            2'b01: begin p = {32'b0, av} * {32'b0, bv}; {r.hi, r.lo} = p; end
            2'b10: if (bv == '0) r.dz = 1'b1;
                   else begin r.lo = 32'(sa / sb); r.hi = 32'(sa % sb); end
            default: if (bv == '0) r.dz = 1'b1;
                     else begin r.lo = av / bv; r.hi = av % bv; end
        endcase
        return r;
    endfunction

    // Timing model: accepted request completes WIDTH+1 edges later (1 for divide by zero).
    logic             m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
    logic [WIDTH-1:0] m_hi = '0, m_lo = '0;
    int               m_left = 0;
    res_t             m_res;

    always @(posedge clock) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
            m_hi <= '0; m_lo <= '0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_done) begin
                m_busy <= 1'b0;
            end else if (m_busy) begin
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_dz   <= m_res.dz;
                    m_hi   <= m_res.hi;
                    m_lo   <= m_res.lo;
                end
                m_left <= m_left - 1;
            end else if (start) begin
                m_res  <= model_calc(op, a, b, m_hi, m_lo);
                m_left <= (op[1] && b == '0) ? 1 : WIDTH + 1;
                m_busy <= 1'b1;
            end
        end
    end

    always @(negedge clock) begin
        if (mon_en) begin
            check("mon_busy", 64'(busy), 64'(m_busy));
            check("mon_done", 64'(done), 64'(m_done));
            check("mon_div_zero", 64'(div_zero), 64'(m_dz));
            check("mon_hi", 64'(hi), 64'(m_hi));
            check("mon_lo", 64'(lo), 64'(m_lo));
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input int exp_lat, output logic [WIDTH-1:0] rhi, output logic [WIDTH-1:0] rlo,
                          output logic rdz);
        int lat;
        @(negedge clock);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clock);
        start = 1'b0; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
        lat = 0;
        while (!done && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        rhi = hi; rlo = lo; rdz = div_zero;
    endtask

    logic [WIDTH-1:0] r_hi, r_lo;
    logic             r_dz;
    int               n_done;

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        @(posedge clock);
        @(negedge clock);
        mon_en = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;

        run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, 33, r_hi, r_lo, r_dz);
        check("mult_hi", 64'(r_hi), 64'hFFFFFFFF);
        check("mult_lo", 64'(r_lo), 64'hFFFFFFEB);
        check("mult_dz", 64'(r_dz), 64'd0);

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, r_hi, r_lo, r_dz);
        check("multu_hi", 64'(r_hi), 64'hFFFFFFFE);
        check("multu_lo", 64'(r_lo), 64'h00000001);

        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 33, r_hi, r_lo, r_dz);
        check("div_neg_lo", 64'(r_lo), 64'hFFFFFFFD);
        check("div_neg_hi", 64'(r_hi), 64'hFFFFFFFF);

        run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, 33, r_hi, r_lo, r_dz);
        check("div_negb_lo", 64'(r_lo), 64'hFFFFFFFD);
        check("div_negb_hi", 64'(r_hi), 64'h00000001);

        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 33, r_hi, r_lo, r_dz);
        check("div_wrap_lo", 64'(r_lo), 64'h80000000);
        check("div_wrap_hi", 64'(r_hi), 64'h0);
        check("div_wrap_dz", 64'(r_dz), 64'd0);

        run_op(OP_DIVU, 32'd100, 32'd0, 1, r_hi, r_lo, r_dz);
        check("divz_dz", 64'(r_dz), 64'd1);
        check("divz_hi", 64'(r_hi), 64'h0);
        check("divz_lo", 64'(r_lo), 64'h80000000);

        run_op(OP_DIVU, 32'hFFFFFFF0, 32'd7, 33, r_hi, r_lo, r_dz);
        check("divu_lo", 64'(r_lo), 64'h24924922);
        check("divu_hi", 64'(r_hi), 64'h00000002);

        // Extra start pulses while busy and during FIN are ignored.
        @(negedge clock);
        start = 1'b1; op = OP_MULT; a = 32'h00010000; b = 32'h00010000;
        n_done = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clock);
            if (done) n_done++;
            start = (i == 5 || i == 33 || i == 34);
            op = OP_DIVU; a = 32'd9; b = 32'd0;
        end
        check("pulse_done_count", 64'(n_done), 64'd1);
        check("pulse_hi", 64'(hi), 64'h1);
        check("pulse_lo", 64'(lo), 64'h0);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clock);
        start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd6;
        n_done = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge clock);
            if (done) n_done++;
            start = 1'b0;
            reset = (i == 10);
        end
        check("abort_done_count", 64'(n_done), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);

        for (int n = 0; n < 40; n++) begin
            logic [1:0]       ro;
            logic [WIDTH-1:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: ra = 32'h80000000;
                1: ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'hFFFFFFFF;
                2: rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, (ro[1] && rb == '0) ? 1 : WIDTH + 1, r_hi, r_lo, r_dz);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
